// File: rtl/pc_sequencer_if.sv
// Decoder/ROM-side bundle for the PC sequencer: branch request and flags in,
// fetch address and sequencer status out.
interface pc_sequencer_if #(
    parameter int AWIDTH = 8,
    parameter int SPW    = 4
);
    logic [2:0]        br_op;
    logic [AWIDTH-1:0] target;
    logic              z;
    logic              o;
    logic              stall;
    logic              resume;
    logic [AWIDTH-1:0] addr;
    logic [SPW-1:0]    sp;
    logic              halted;
    logic              fault;
    logic [1:0]        err_code;

    modport master (
        output br_op, target, z, o, stall, resume,
        input  addr, sp, halted, fault, err_code
    );

    modport slave (
        input  br_op, target, z, o, stall, resume,
        output addr, sp, halted, fault, err_code
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with hardware return stack, halt and fault states.
// Latency: new PC appears one rising edge after the branch op is presented.
// Backpressure: stall freezes PC, SP and stack; halt waits for a resume pulse.
module pc_sequencer #(
    parameter int                AWIDTH      = 8,
    parameter int                STACK_DEPTH = 8,
    parameter logic [AWIDTH-1:0] RESET_VEC   = '0
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    localparam int SPW = $clog2(STACK_DEPTH) + 1;
    localparam int IW  = SPW - 1;

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JZ   = 3'd2;
    localparam logic [2:0] OP_JMPO = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_SRST = 3'd6;

    typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

    state_t            state;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] stack [STACK_DEPTH];
    logic [SPW-1:0]    sp;
    logic              halted;
    logic              fault;
    logic [1:0]        err;

    logic [AWIDTH-1:0] pc_inc;
    logic [SPW-1:0]    sp_dec;
    logic              full;
    logic              empty;

    assign pc_inc = pc + AWIDTH'(1);
    assign sp_dec = sp - SPW'(1);
    assign full   = (sp == SPW'(STACK_DEPTH));
    assign empty  = (sp == '0);

    // Stack entries are deliberately left out of reset; only SP gives them meaning.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_RUN;
            pc     <= RESET_VEC;
            sp     <= '0;
            halted <= 1'b0;
            fault  <= 1'b0;
            err    <= 2'b00;
        end else begin
            case (state)
                S_RUN: begin
                    if (!bus.stall) begin
                        case (bus.br_op)
                            OP_NEXT: pc <= pc_inc;
                            OP_JMP:  pc <= bus.target;
                            OP_JZ:   pc <= bus.z ? bus.target : pc_inc;
                            OP_JMPO: pc <= bus.o ? bus.target : pc_inc;
                            OP_CALL: begin
                                if (full) begin
                                    state <= S_FAULT;
                                    fault <= 1'b1;
                                    err   <= 2'b01;
                                end else begin
                                    stack[sp[IW-1:0]] <= pc_inc;
                                    sp <= sp + SPW'(1);
                                    pc <= bus.target;
                                end
                            end
                            OP_RET: begin
                                if (empty) begin
                                    state <= S_FAULT;
                                    fault <= 1'b1;
                                    err   <= 2'b10;
                                end else begin
                                    pc <= stack[sp_dec[IW-1:0]];
                                    sp <= sp_dec;
                                end
                            end
                            OP_SRST: begin
                                pc <= RESET_VEC;
                                sp <= '0;
                            end
                            default: begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end
                        endcase
                    end
                end
                S_HALT: begin
                    if (bus.resume) begin
                        state  <= S_RUN;
                        halted <= 1'b0;
                        pc     <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.addr     = pc;
    assign bus.sp       = sp;
    assign bus.halted   = halted;
    assign bus.fault    = fault;
    assign bus.err_code = err;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the one-cycle CPU. It drives the 8-bit address into the combinational instruction ROM and computes the next PC from the branch operation given by the decoder. Branch operations are next, jump, conditional jump, call/return through an internal hardware return stack, soft restart, and halt. It sits between the instruction decoder/ALU flags and the ROM address input, and replaces ad-hoc PC logic in the core.

Parameters:
AWIDTH, 8, ROM address width (PC width)
STACK_DEPTH, 8, number of return-stack entries (power of two, >=2)
RESET_VEC, 8'h00, PC value after reset and after soft restart

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST_N  input  1  synchronous active-low reset
BR_OP  input  3  branch op: 0 NEXT, 1 JMP, 2 JZ, 3 JMPO, 4 CALL, 5 RET, 6 SRST, 7 HALT
TARGET  input  AWIDTH  branch/call target (instruction operand field)
Z  input  1  ALU zero flag
O  input  1  ALU overflow flag
STALL  input  1  freeze PC and stack this cycle
RESUME  input  1  single-cycle pulse that leaves HALT
ADDR  output  AWIDTH  current PC, drives ROM ADDR
SP  output  clog2(STACK_DEPTH)+1  current stack occupancy (0..STACK_DEPTH)
HALTED  output  1  high in HALT state
FAULT  output  1  high in FAULT state
ERR_CODE  output  2  00 none, 01 stack overflow, 10 stack underflow

Behaviour:
- Reset has priority over all other inputs. When RST_N=0 at a rising edge: ADDR=RESET_VEC, SP=0, state=RUN, HALTED=0, FAULT=0, ERR_CODE=00. Stack contents are don't-care.
- ADDR is the PC register output with no combinational path from inputs. The ROM returns the instruction in the same cycle, the decoder produces BR_OP/TARGET in that cycle, and the new PC appears after the next rising edge (1-cycle fetch-to-next).
- States: RUN, HALT, FAULT. HALTED=(state==HALT), FAULT=(state==FAULT).
- In RUN with STALL=1: PC, SP and state hold, and BR_OP is ignored. STALL has priority over HALT and branch ops.
- In RUN with STALL=0, PC+1 is computed modulo 2^AWIDTH (FF->00):
  - NEXT: PC<=PC+1.
  - JMP: PC<=TARGET.
  - JZ: PC<=Z?TARGET:PC+1.
  - JMPO: PC<=O?TARGET:PC+1.
  - CALL with SP<STACK_DEPTH: stack[SP]<=PC+1, SP<=SP+1, PC<=TARGET.
  - CALL with SP==STACK_DEPTH: state<=FAULT, ERR_CODE<=01, PC/SP/stack unchanged.
  - RET with SP>0: PC<=stack[SP-1], SP<=SP-1.
  - RET with SP==0: state<=FAULT, ERR_CODE<=10, PC unchanged.
  - SRST: PC<=RESET_VEC, SP<=0, ERR_CODE unchanged (already 00).
  - HALT: state<=HALT, PC held at the HALT instruction address.
- HALT: PC, SP and stack hold, and BR_OP and STALL are ignored. RESUME=1 -> state<=RUN, PC<=PC+1 (wrapping). A RESUME asserted in RUN or FAULT has no effect.
- FAULT: all state frozen, ADDR holds, and ERR_CODE holds its value. Exit only via RST_N=0.
- Z and O are sampled only when BR_OP is JZ or JMPO respectively.
- Full stack plus RET is legal (pop). Empty stack plus CALL is legal (push). Wrap of a pushed return address (CALL at FF pushes 00) is legal.

Test Plan:
- Reset: RST_N=0 for 2 cycles, then BR_OP=NEXT x3 -> ADDR 00,01,02,03; SP=0, HALTED=0, FAULT=0, ERR_CODE=00. Reassert RST_N mid-run at ADDR=05 -> ADDR=00 next edge.
- Wrap and stall: JMP TARGET=FF -> ADDR=FF. NEXT -> ADDR=00. NEXT with STALL=1 for 3 cycles -> ADDR stays 00, then 01 after STALL drops.
- Conditional: at ADDR=12, JZ TARGET=15 with Z=0 -> 13. Repeat with Z=1 -> 15. JMPO TARGET=03 with O=1 -> 03, with O=0 -> PC+1.
- Call/return: at ADDR=0D, CALL TARGET=11 -> ADDR=11, SP=1. NEXT x3 -> 14. RET -> ADDR=0E, SP=0. Nested: 8 CALLs -> SP=8, 8 RETs return addresses in LIFO order.
- Stack faults: with SP=8, CALL -> FAULT=1, ERR_CODE=01, ADDR and SP=8 unchanged, further ops and RESUME ignored. After reset, RET -> FAULT=1, ERR_CODE=10, ADDR=00.
- Halt/resume/soft restart: at ADDR=20, HALT -> HALTED=1, ADDR=20 held for 5 cycles despite BR_OP=JMP. RESUME pulse -> ADDR=21, HALTED=0. SRST with SP=3 -> ADDR=RESET_VEC, SP=0.
